// File: rtl/dma_mc_engine.sv
// Multi-channel memory-to-memory DMA engine with round-robin beat arbitration.
// Ports:
//   clk, arst                  clock, asynchronous active-high reset
//   ctrl_data/addr/WR_en/RD_en register bus (write data, address, strobes)
//   Rdata, Valid               registered read data and its 1-cycle qualifier
//   dma_busy, Interupt         OR of active bits; OR of (done & irq_en)
//   mem_rd_addr, mem_rd_data   memory read port (data valid one cycle after addr)
//   mem_wr_en/addr/data        memory write port
module dma_mc_engine #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] ctrl_data,
    input  logic [WIDTH-1:0] ctrl_addr,
    input  logic             ctrl_WR_en,
    input  logic             ctrl_RD_en,
    output logic [WIDTH-1:0] Rdata,
    output logic             Valid,
    output logic             dma_busy,
    output logic             Interupt,
    output logic [WIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data
);

    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(8'hF0);
    localparam logic [WIDTH-1:0] ADDR_BUSY   = WIDTH'(8'hF1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  src_q [NUM_CH];
    logic [WIDTH-1:0]  dst_q [NUM_CH];
    logic [WIDTH-1:0]  len_q [NUM_CH];
    logic [NUM_CH-1:0] irq_en_q, src_fixed_q, dst_fixed_q, active_q, done_q;
    logic [CHW-1:0]    rr_ptr_q, grant_q;

    logic [WIDTH-1:0]  src_nxt_c, dst_nxt_c, len_nxt_c, rd_value_c;
    logic              last_beat_c;
    logic [NUM_CH-1:0] act_after_c, fsm_done_c, start_c, zero_start_c, w1c_c;
    logic [CHW-1:0]    ptr_after_c;
    logic [CHW:0]      idle_pick_c, wr_pick_c;

    // First set bit of act at or after ptr, wrapping; MSB of result flags "found".
    function automatic logic [CHW:0] pick(input logic [NUM_CH-1:0] act,
                                          input logic [CHW-1:0] ptr);
        logic [CHW:0] r;
        r = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i) % int'(NUM_CH);
            if (act[j]) r = {1'b1, CHW'(j)};
        end
        return r;
    endfunction

    // Beat bookkeeping for the granted channel and re-arbitration after it.
    always_comb begin
        src_nxt_c   = src_fixed_q[grant_q] ? src_q[grant_q] : src_q[grant_q] + WIDTH'(1);
        dst_nxt_c   = dst_fixed_q[grant_q] ? dst_q[grant_q] : dst_q[grant_q] + WIDTH'(1);
        len_nxt_c   = len_q[grant_q] - WIDTH'(1);
        last_beat_c = (len_q[grant_q] == WIDTH'(1));
        fsm_done_c  = '0;
        if (state_q == WRITE && last_beat_c) fsm_done_c[grant_q] = 1'b1;
        act_after_c = active_q & ~fsm_done_c;
        ptr_after_c = (grant_q == CHW'(NUM_CH - 1)) ? '0 : grant_q + CHW'(1);
        idle_pick_c = pick(active_q, rr_ptr_q);
        wr_pick_c   = pick(act_after_c, ptr_after_c);
    end

    // Register read mux and write-side strobes derived from the ctrl bus.
    always_comb begin
        rd_value_c   = '0;
        start_c      = '0;
        zero_start_c = '0;
        w1c_c        = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ctrl_addr == WIDTH'(4 * c))     rd_value_c = src_q[c];
            if (ctrl_addr == WIDTH'(4 * c + 1)) rd_value_c = dst_q[c];
            if (ctrl_addr == WIDTH'(4 * c + 2)) rd_value_c = len_q[c];
            if (ctrl_addr == WIDTH'(4 * c + 3))
                rd_value_c = WIDTH'({dst_fixed_q[c], src_fixed_q[c], irq_en_q[c], 1'b0});
            if (ctrl_WR_en && ctrl_addr == WIDTH'(4 * c + 3) && ctrl_data[0] && !active_q[c]) begin
                if (len_q[c] == '0) zero_start_c[c] = 1'b1;
                else                start_c[c]      = 1'b1;
            end
        end
        if (ctrl_addr == ADDR_STATUS) rd_value_c[NUM_CH-1:0] = done_q;
        if (ctrl_addr == ADDR_BUSY)   rd_value_c[NUM_CH-1:0] = active_q;
        if (ctrl_WR_en && ctrl_addr == ADDR_STATUS) w1c_c = ctrl_data[NUM_CH-1:0];
    end

    // Channel registers, status bits, read port and transfer FSM.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            irq_en_q    <= '0;
            src_fixed_q <= '0;
            dst_fixed_q <= '0;
            active_q    <= '0;
            done_q      <= '0;
            Rdata       <= '0;
            Valid       <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
        end else begin
            Valid <= ctrl_RD_en;
            if (ctrl_RD_en) Rdata <= rd_value_c;

            // Software writes; an active channel only accepts irq_en.
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (ctrl_WR_en && !active_q[c]) begin
                    if (ctrl_addr == WIDTH'(4 * c))     src_q[c] <= ctrl_data;
                    if (ctrl_addr == WIDTH'(4 * c + 1)) dst_q[c] <= ctrl_data;
                    if (ctrl_addr == WIDTH'(4 * c + 2)) len_q[c] <= ctrl_data;
                end
                if (ctrl_WR_en && ctrl_addr == WIDTH'(4 * c + 3)) begin
                    irq_en_q[c] <= ctrl_data[1];
                    if (!active_q[c]) begin
                        src_fixed_q[c] <= ctrl_data[2];
                        dst_fixed_q[c] <= ctrl_data[3];
                    end
                end
            end

            // Hardware set of done takes priority over a same-cycle W1C.
            done_q   <= (done_q & ~w1c_c) | zero_start_c | fsm_done_c;
            active_q <= (active_q | start_c) & ~fsm_done_c;

            mem_wr_en <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (idle_pick_c[CHW]) begin
                        grant_q     <= idle_pick_c[CHW-1:0];
                        mem_rd_addr <= src_q[idle_pick_c[CHW-1:0]];
                        state_q     <= READ;
                    end
                end
                READ: begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= dst_q[grant_q];
                    state_q     <= WRITE;
                end
                WRITE: begin
                    src_q[grant_q] <= src_nxt_c;
                    dst_q[grant_q] <= dst_nxt_c;
                    len_q[grant_q] <= len_nxt_c;
                    rr_ptr_q       <= ptr_after_c;
                    if (wr_pick_c[CHW]) begin
                        grant_q <= wr_pick_c[CHW-1:0];
                        // Same channel again must use its freshly advanced SRC.
                        mem_rd_addr <= (wr_pick_c[CHW-1:0] == grant_q) ? src_nxt_c
                                                                      : src_q[wr_pick_c[CHW-1:0]];
                        state_q <= READ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dma_busy    = |active_q;
    assign Interupt    = |(done_q & irq_en_q);
    // Read data arrives during WRITE; pass it straight to the write port.
    assign mem_wr_data = mem_wr_en ? mem_rd_data : '0;

endmodule

// File: doc/dma_mc_engine.md
Name: dma_mc_engine

Overview:
Parametrised multi-channel DMA engine, successor to the single-channel engine.
- NUM_CH independent channels, each with its own source, destination and length registers.
- Round-robin arbitration between channels, one beat at a time.
- Moves words memory-to-memory over a shared synchronous memory port (1-cycle read latency).
- Controlled through the existing ctrl_* register bus; raises Interupt on channel completion.

Parameters:
WIDTH, 8, data/address width of the ctrl bus and memory port.
NUM_CH, 2, number of channels (1..4).

Ports:
clk  in  1  system clock, all logic on its rising edge.
arst  in  1  asynchronous, active-high reset.
ctrl_data  in  WIDTH  register write data.
ctrl_addr  in  WIDTH  register address.
ctrl_WR_en  in  1  register write strobe, one cycle per write.
ctrl_RD_en  in  1  register read strobe, one cycle per read.
Rdata  out  WIDTH  register read data.
Valid  out  1  Rdata qualifier, 1-cycle pulse.
dma_busy  out  1  OR of all channel active bits.
Interupt  out  1  level; OR over channels of (done & irq_en).
mem_rd_addr  out  WIDTH  memory read address.
mem_rd_data  in  WIDTH  memory read data, valid the cycle after mem_rd_addr.
mem_wr_en  out  1  memory write enable.
mem_wr_addr  out  WIDTH  memory write address.
mem_wr_data  out  WIDTH  memory write data.

Behaviour:
- Reset: the registers below clear to 0 asynchronously. FSM goes to IDLE and the round-robin pointer goes to channel 0.
  - All outputs: Rdata, Valid, dma_busy, Interupt, mem_*.
  - All channel registers and done/active bits.
- Register map, channel c at base 4*c:
  - +0 SRC
  - +1 DST
  - +2 LEN (beats)
  - +3 CTRL: bit0 start (write-only, self-clearing), bit1 irq_en, bit2 src_fixed, bit3 dst_fixed.
  - 0xF0 STATUS: done[NUM_CH-1:0]; write-1-to-clear.
  - 0xF1 BUSY: active[NUM_CH-1:0]; read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- Register reads: Rdata is registered. Valid=1 and Rdata=value exactly one cycle after ctrl_RD_en; otherwise Valid=0 and Rdata holds.
- Writes while a channel is active:
  - SRC, DST and LEN writes are dropped.
  - A CTRL write updates only irq_en.
  - start is ignored.
- Start: writing CTRL with bit0=1 while the channel is idle sets active.
  - If LEN=0, active is not set; done is set the next cycle and no memory access occurs.
- FSM states: IDLE, READ, WRITE.
  - IDLE: if any channel is active, grant the first active channel at or after rr_ptr, then go to READ. Otherwise stay in IDLE.
  - READ: mem_rd_addr = SRC[g]; go to WRITE.
  - WRITE:
    - Outputs: mem_wr_en=1, mem_wr_addr=DST[g], mem_wr_data=mem_rd_data.
    - Updates: SRC+=1 unless src_fixed; DST+=1 unless dst_fixed (both modulo 2^WIDTH); LEN-=1.
    - If LEN was 1: clear active[g] and set done[g].
    - rr_ptr = g+1 (mod NUM_CH).
    - Next state: re-arbitrate over the active set with active[g] already updated, going to READ if any channel is active, else IDLE.
- Timing: each beat takes 2 cycles back-to-back. The first beat's mem_rd_addr appears 2 cycles after the start write (IDLE, then READ).
- mem_wr_en is 0 outside WRITE. mem_rd_addr holds its last value outside READ.
- Simultaneous hardware done-set and software W1C on the same bit: set wins.
- Address wrap: SRC/DST wrap from 2^WIDTH-1 to 0 silently.
- dma_busy and Interupt are combinational from registered state.

Test Plan:
- Reset mid-transfer: assert arst during WRITE of ch0 -> same cycle mem_wr_en=0, dma_busy=0; after release all registers read 0.
- Single transfer, ch0: memory 0x10..0x13=A0..A3, SRC=0x10, DST=0x40, LEN=4, CTRL=0x03 -> 4 writes at 0x40..0x43 with A0..A3, one every 2 cycles; Interupt=1; STATUS reads 0x01; write 0x01 to 0xF0 -> Interupt=0.
- Two channels, ch0 LEN=3 and ch1 LEN=2, started in the same cycle -> write order ch0, ch1, ch0, ch1, ch0; BUSY=0x01 after the 4th write; both done.
- Fixed modes: src_fixed=1, dst_fixed=1, SRC=0x20 (=0x5A), LEN=3 -> three writes of 0x5A, all to DST.
- LEN=0 start -> no mem_wr_en, done set next cycle. SRC=0xFE, LEN=3 -> reads at 0xFE, 0xFF, 0x00.
- Write SRC of an active channel -> value unchanged on read-back. Read of 0x80 -> Valid=1, Rdata=0.
